// File: rtl/tabla_seq_ctrl.sv
// rtl/tabla_seq_ctrl.sv - truth-table sweep sequencer comparing a gate-level and an operator implementation
module tabla_seq_ctrl #(
  parameter int unsigned STEP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_a,
  input  logic       y_b,
  output logic [2:0] vec,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_cnt,
  output logic       fail_valid,
  output logic [2:0] first_fail,
  output logic [7:0] table_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // APPLY covers STEP_CYCLES-1 cycles and SAMPLE one more, so each vector is driven STEP_CYCLES cycles
  localparam logic [7:0] HOLD_LAST = 8'(STEP_CYCLES - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] mm_q, mm_d;
  logic       fv_q, fv_d;
  logic [2:0] ff_q, ff_d;
  logic [7:0] tbl_q, tbl_d;

  logic       differ;
  assign differ = (y_a != y_b);

  // State and output registers; reset forces everything back to the idle values at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      vec_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mm_q    <= 4'd0;
      fv_q    <= 1'b0;
      ff_q    <= 3'd0;
      tbl_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      mm_q    <= mm_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      tbl_q   <= tbl_d;
    end
  end

  // Next-state logic; registered outputs are computed from the state being entered
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    mm_d    = mm_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    tbl_d   = tbl_q;

    case (state_q)
      IDLE: begin
        vec_d  = 3'd0;
        cnt_d  = 8'd0;
        busy_d = 1'b0;
        // abort outranks start, so a simultaneous request starts nothing
        if (start && !abort) begin
          state_d = APPLY;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          mm_d    = 4'd0;
          fv_d    = 1'b0;
          ff_d    = 3'd0;
          tbl_d   = 8'd0;
        end
      end

      APPLY: begin
        if (abort) begin
          state_d = IDLE;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      SAMPLE: begin
        if (abort) begin
          // the sample taken in this cycle is dropped; earlier partial results stay visible
          state_d = IDLE;
          vec_d   = 3'd0;
          cnt_d   = 8'd0;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          tbl_d[vec_q] = y_a;
          if (differ) begin
            mm_d = mm_q + 4'd1;
            if (!fv_q) begin
              ff_d = vec_q;
              fv_d = 1'b1;
            end
          end
          cnt_d = 8'd0;
          if (vec_q == 3'd7) begin
            state_d = DONE;
            vec_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // include the final vector's comparison in the verdict
            pass_d  = (mm_q == 4'd0) && !differ;
          end else begin
            state_d = APPLY;
            vec_d   = vec_q + 3'd1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;
  assign fail_valid   = fv_q;
  assign first_fail   = ff_q;
  assign table_out    = tbl_q;

endmodule

// File: tb/tb_tabla_seq_ctrl.sv
// tb/tb_tabla_seq_ctrl.sv - scoreboard bench for tabla_seq_ctrl
module tb_tabla_seq_ctrl;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       y_a, y_b;
  logic [2:0] vec;
  logic       busy, done, pass, fail_valid;
  logic [3:0] mismatch_cnt;
  logic [2:0] first_fail;
  logic [7:0] table_out;

  logic [7:0] f_tbl = 8'd0;
  logic [7:0] fault_mask = 8'd0;

  assign y_a = f_tbl[vec];
  assign y_b = f_tbl[vec] ^ fault_mask[vec];

  tabla_seq_ctrl #(.STEP_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .y_a(y_a), .y_b(y_b), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .mismatch_cnt(mismatch_cnt), .fail_valid(fail_valid),
    .first_fail(first_fail), .table_out(table_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pass;
    logic [3:0] mm;
    logic       fv;
    logic [2:0] ff;
    logic [7:0] tbl;
  } res_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  res_t       sb[$];
  logic [2:0] trace[$];
  int         lat;
  logic [7:0] gate_tbl;

  function automatic res_t model(input logic [7:0] tbl, input logic [7:0] mask);
    res_t r;
    r.tbl = tbl;
    r.mm  = 4'd0;
    r.fv  = 1'b0;
    r.ff  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        r.mm = r.mm + 4'd1;
        if (!r.fv) begin
          r.fv = 1'b1;
          r.ff = 3'(i);
        end
      end
    end
    r.pass = (mask == 8'd0);
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r = {pass, mismatch_cnt, fail_valid, first_fail, table_out};
    return r;
  endfunction

  task automatic do_sweep(input logic hold);
    @(negedge clk);
    start = 1'b1;
    sb.push_back(model(f_tbl, fault_mask));
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    trace.delete();
    lat = 1;
    while (!done && lat < 200) begin
      trace.push_back(vec);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int k = 0;
    while (vec !== v && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    #12;
    n_cmp++;
    if ({vec, busy, done, observed()} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h required 0", {vec, busy, done, observed()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({vec, busy, done} !== '0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %h required 0", {vec, busy, done});
    end
  endtask

  task automatic test_matched();
    res_t exp, got;
    int errs = 0;
    fault_mask = 8'd0;
    f_tbl = gate_tbl;
    do_sweep(1'b0);
    n_cmp++;
    if (lat !== 8*S+1) begin
      n_bad++;
      $display("FAIL matched_latency: got %0d required %0d", lat, 8*S+1);
    end
    exp = sb.pop_front();
    got = observed();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL matched_result: got %h required %h", got, exp);
    end
    n_cmp++;
    if (table_out !== 8'hEA) begin
      n_bad++;
      $display("FAIL matched_table: got %h required ea", table_out);
    end
    if (trace.size() != 8*S) errs++;
    foreach (trace[k]) if (trace[k] !== 3'(k / S)) errs++;
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL vec_sequence: got %0d bad steps required 0", errs);
    end
    @(negedge clk);
    n_cmp++;
    if ({done, busy} !== 2'b00) begin
      n_bad++;
      $display("FAIL done_single_pulse: got done,busy=%b required 00", {done, busy});
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (observed() !== exp) begin
      n_bad++;
      $display("FAIL result_hold: got %h required %h", observed(), exp);
    end
  endtask

  task automatic test_faults();
    res_t exp, got;
    logic [7:0] masks[4];
    masks[0] = 8'b0010_0000;
    masks[1] = 8'hFF;
    masks[2] = 8'($urandom);
    masks[3] = 8'($urandom) | 8'h80;
    for (int m = 0; m < 4; m++) begin
      fault_mask = masks[m];
      f_tbl = (m < 2) ? gate_tbl : 8'($urandom);
      do_sweep(1'b0);
      exp = sb.pop_front();
      got = observed();
      n_cmp++;
      if (got !== exp || lat !== 8*S+1) begin
        n_bad++;
        $display("FAIL fault_sweep_%0d: got %h lat %0d required %h lat %0d",
                 m, got, lat, exp, 8*S+1);
      end
    end
    f_tbl = gate_tbl;
  endtask

  task automatic test_abort();
    res_t exp;
    int ndone = 0;
    fault_mask = 8'b0000_0010;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_vec(3'd3);
    abort = 1'b1;
    exp = model(gate_tbl & 8'h07, fault_mask & 8'h07);
    exp.pass = 1'b0;
    sb.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if ({busy, done, pass, vec} !== 6'd0) begin
      n_bad++;
      $display("FAIL abort_idle: got busy,done,pass,vec=%b required 0", {busy, done, pass, vec});
    end
    exp = sb.pop_front();
    n_cmp++;
    if (observed() !== exp) begin
      n_bad++;
      $display("FAIL abort_partial: got %h required %h", observed(), exp);
    end
    repeat (40) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_bad++;
      $display("FAIL abort_no_done: got %0d active cycles required 0", ndone);
    end
    fault_mask = 8'd0;
    do_sweep(1'b0);
    exp = sb.pop_front();
    n_cmp++;
    if (observed() !== exp || lat !== 8*S+1) begin
      n_bad++;
      $display("FAIL after_abort_sweep: got %h lat %0d required %h", observed(), lat, exp);
    end
  endtask

  task automatic test_start_hold();
    res_t exp;
    int extra = 0;
    fault_mask = 8'b1000_0000;
    do_sweep(1'b1);
    exp = sb.pop_front();
    n_cmp++;
    if (observed() !== exp || lat !== 8*S+1) begin
      n_bad++;
      $display("FAIL held_start_sweep: got %h lat %0d required %h", observed(), lat, exp);
    end
    repeat (20) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    start = 1'b1;
    abort = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL no_second_sweep: got %0d active cycles required 0", extra);
    end
    n_cmp++;
    if (observed() !== exp) begin
      n_bad++;
      $display("FAIL start_abort_keeps_result: got %h required %h", observed(), exp);
    end
  endtask

  task automatic test_reset_mid();
    res_t exp;
    fault_mask = 8'hFF;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_vec(3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vec, busy, done, observed()} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got %h required 0", {vec, busy, done, observed()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fault_mask = 8'd0;
    do_sweep(1'b0);
    exp = sb.pop_front();
    n_cmp++;
    if (observed() !== exp || lat !== 8*S+1 || trace[0] !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset_sweep: got %h lat %0d required %h", observed(), lat, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      gate_tbl[i] = (v[2] & v[1]) | v[0];
    end
    f_tbl = gate_tbl;
    test_reset();
    test_matched();
    test_faults();
    test_abort();
    test_start_hold();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/tabla_seq_ctrl.md
TABLA_SEQ_CTRL -- requirements
Module: tabla_seq_ctrl

Interface
REQ-001 Parameter STEP_CYCLES, default 4: cycles each input vector is held before sampling; legal range 2..255.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; one clock domain.
REQ-004 start  input  1  request a full 8-vector sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate a sweep in progress.
REQ-006 y_a  input  1  output of the gate-level implementation (LED1 path).
REQ-007 y_b  input  1  output of the operator implementation (LED2 path).
REQ-008 vec  output  3  applied inputs {A,B,C}, shared by both implementations.
REQ-009 busy  output  1  high while a sweep is running.
REQ-010 done  output  1  single-cycle pulse on sweep completion.
REQ-011 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-012 mismatch_cnt  output  4  number of vectors where y_a != y_b, range 0..8.
REQ-013 fail_valid  output  1  high when at least one mismatch recorded.
REQ-014 first_fail  output  3  lowest vector at which y_a != y_b.
REQ-015 table_out  output  8  captured truth table of y_a; bit i = y_a sampled for vec==i.

Function
REQ-016 FSM states IDLE, APPLY, SAMPLE, DONE; all outputs registered.
REQ-017 IDLE: vec=0, busy=0; start=1 and abort=0 -> APPLY next cycle, result registers cleared at that edge.
REQ-018 APPLY: hold vec, increment hold counter from 0; at count STEP_CYCLES-2 -> SAMPLE.
REQ-019 SAMPLE (one cycle): table_out[vec] <= y_a; if y_a!=y_b, mismatch_cnt +1 and, if fail_valid==0, first_fail <= vec and fail_valid <= 1.
REQ-020 SAMPLE with vec<7 -> vec+1, counter cleared, APPLY; vec==7 -> DONE, vec returns to 0.
REQ-021 Each vector is therefore driven exactly STEP_CYCLES cycles; start-accept edge to done pulse = 8*STEP_CYCLES+1 cycles.
REQ-022 DONE (one cycle): done=1, busy=0, pass <= (mismatch_cnt==0 including final sample); -> IDLE.
REQ-023 busy=1 in APPLY and SAMPLE only.
REQ-024 start while busy or in DONE is ignored; no queuing.
REQ-025 abort in APPLY/SAMPLE -> IDLE next cycle; no done pulse; pass <= 0; the aborting SAMPLE cycle's result is discarded; partial table_out/mismatch_cnt/first_fail retained until next start.
REQ-026 abort and start both high in IDLE: abort wins, sweep not started.
REQ-027 Result registers (pass, mismatch_cnt, fail_valid, first_fail, table_out) hold after DONE until the next accepted start.
REQ-028 vec never exceeds 7; no wrap from 7 to 0 within a sweep other than the return at DONE.

Reset
REQ-029 rst_n low asynchronously forces IDLE; vec=0, busy=0, done=0, pass=0, mismatch_cnt=0, fail_valid=0, first_fail=0, table_out=0, hold counter=0.
REQ-030 Reset mid-sweep discards all progress; first post-reset rising edge with start=1 begins a fresh sweep at vec=0.
REQ-031 Release of rst_n is synchronous-deasserted upstream; block needs no internal synchronizer.

Verification
REQ-032 Matched: y_a=y_b=(A&B)|C, STEP_CYCLES=4, start pulse -> done at cycle 33 after accept, pass=1, mismatch_cnt=0, table_out=8'hEA.
REQ-033 Single fault: y_b = y_a inverted only for vec=5 -> pass=0, mismatch_cnt=1, fail_valid=1, first_fail=5.
REQ-034 Total fault: y_b=~y_a -> mismatch_cnt=8, first_fail=0, pass=0.
REQ-035 Abort at vec=3 in APPLY -> busy=0 next cycle, no done pulse, pass=0; new start then completes normal sweep.
REQ-036 start held high through sweep plus start+abort together in IDLE -> exactly one sweep, one done pulse; simultaneous case starts nothing.
REQ-037 rst_n low at vec=6 -> all outputs at reset values immediately, without waiting for clk.
